// File: rtl/scaler_h_linear_if.sv
// Video stream bundle for the horizontal linear scaler: the input pixel
// stream with its sync pulses, the output stream, and the step setting.
interface scaler_h_linear_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic [15:0]            scale_step;
  logic [PIXEL_WIDTH-1:0] di_i;
  logic                   de_i;
  logic                   hs_i;
  logic                   vs_i;
  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;

  // Source side: drives the input stream and consumes the scaled stream.
  modport master (
    output scale_step, di_i, de_i, hs_i, vs_i,
    input  do_o, de_o, hs_o, vs_o
  );

  // Scaler side: consumes the input stream and drives the scaled stream.
  modport slave (
    input  scale_step, di_i, de_i, hs_i, vs_i,
    output do_o, de_o, hs_o, vs_o
  );
endinterface

// File: rtl/scaler_h_linear.sv
// Horizontal linear-interpolating downscaler (unity or reduction only).
// Output sample k of a line sits at position k*step in fixed-point input
// units; it is produced when the input pixel just to its right arrives,
// blending that pixel with its left neighbour. Three register stages:
// decision/coefficient, weighted sum, output.
module scaler_h_linear #(
  parameter int PIXEL_STEP  = 128,
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 8
) (
  input logic              clk,
  input logic              rst_n,
  scaler_h_linear_if.slave bus
);

  localparam int CNT_W     = 24;
  localparam int STEP_LOG2 = $clog2(PIXEL_STEP);
  localparam int FRAC_W    = CNT_W + COE_WIDTH;
  localparam int SUM_W     = PIXEL_WIDTH + COE_WIDTH + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(PIXEL_STEP);

  // Line state
  logic [CNT_W-1:0]       pos;
  logic [CNT_W-1:0]       acc;
  logic [15:0]            step_q;
  logic [PIXEL_WIDTH-1:0] p0;
  logic                   active;

  // Stage 1: interpolation operands
  logic                   s1_valid;
  logic                   s1_hs;
  logic                   s1_vs;
  logic [PIXEL_WIDTH-1:0] s1_p0;
  logic [PIXEL_WIDTH-1:0] s1_p1;
  logic [COE_WIDTH-1:0]   s1_coe;

  // Stage 2: weighted sum
  logic                   s2_valid;
  logic                   s2_hs;
  logic                   s2_vs;
  logic [SUM_W-1:0]       s2_sum;

  // Stage 3: output registers
  logic [PIXEL_WIDTH-1:0] do_q;
  logic                   de_q;
  logic                   hs_q;
  logic                   vs_q;

  logic [15:0]            eff_step_in;
  logic [CNT_W-1:0]       frac;
  logic [COE_WIDTH-1:0]   coe_next;
  logic                   emit;
  logic [COE_WIDTH:0]     w0;
  logic [SUM_W-1:0]       prod0;
  logic [SUM_W-1:0]       prod1;

  // Clamp the requested pitch to unity so the scaler never upsamples, and
  // decide whether the arriving pixel closes off the next output position.
  always_comb begin
    eff_step_in = (bus.scale_step < 16'(PIXEL_STEP)) ? 16'(PIXEL_STEP) : bus.scale_step;
    frac        = acc + STEP_C - pos;
    coe_next    = COE_WIDTH'((FRAC_W'(frac) << COE_WIDTH) >> STEP_LOG2);
    emit        = bus.de_i && !bus.hs_i && (pos != '0) && (acc < pos);
  end

  // Line bookkeeping and stage 1: a line start wins over a coincident pixel,
  // which then becomes pixel 0 of the fresh line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= '0;
      acc      <= '0;
      step_q   <= 16'(PIXEL_STEP);
      p0       <= '0;
      active   <= 1'b0;
      s1_valid <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_p0    <= '0;
      s1_p1    <= '0;
      s1_coe   <= '0;
    end else begin
      s1_hs    <= bus.hs_i;
      s1_vs    <= bus.vs_i;
      s1_valid <= 1'b0;
      if (bus.hs_i) begin
        step_q <= eff_step_in;
        acc    <= '0;
        active <= 1'b1;
        if (bus.de_i) begin
          p0  <= bus.di_i;
          pos <= STEP_C;
        end else begin
          p0  <= '0;
          pos <= '0;
        end
      end else if (bus.de_i) begin
        p0  <= bus.di_i;
        pos <= pos + STEP_C;
        if (emit) begin
          acc      <= acc + CNT_W'(step_q);
          s1_valid <= active;
          s1_p0    <= p0;
          s1_p1    <= bus.di_i;
          s1_coe   <= coe_next;
        end
      end
    end
  end

  // Blend weights are complementary, so the full-precision sum never
  // exceeds the largest pixel value scaled by 2^COE_WIDTH.
  always_comb begin
    w0    = {1'b1, {COE_WIDTH{1'b0}}} - {1'b0, s1_coe};
    prod0 = SUM_W'(s1_p0) * SUM_W'(w0);
    prod1 = SUM_W'(s1_p1) * SUM_W'(s1_coe);
  end

  // Stage 2: register the weighted sum alongside the sync pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_hs    <= 1'b0;
      s2_vs    <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      if (s1_valid) begin
        s2_sum <= prod0 + prod1;
      end
    end
  end

  // Stage 3: normalise the sum; the pixel output holds between samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_q <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= s2_valid;
      hs_q <= s2_hs;
      vs_q <= s2_vs;
      if (s2_valid) begin
        do_q <= PIXEL_WIDTH'(s2_sum >> COE_WIDTH);
      end
    end
  end

  assign bus.do_o = do_q;
  assign bus.de_o = de_q;
  assign bus.hs_o = hs_q;
  assign bus.vs_o = vs_q;

endmodule

// File: tb/tb_scaler_h_linear.sv
// Bench for the horizontal linear scaler: a line-level model computes each
// output sample from its position k*step, every cycle is compared against
// the model, and a few directed lines pin both model and design to
// hand-worked values.
module tb_scaler_h_linear;

  localparam int PIXEL_STEP  = 128;
  localparam int PIXEL_WIDTH = 8;
  localparam int COE_WIDTH   = 8;
  localparam int WIDE_W      = 2688;

  typedef struct {
    logic                   de;
    logic                   hs;
    logic                   vs;
    logic [PIXEL_WIDTH-1:0] dat;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  scaler_h_linear_if #(.PIXEL_WIDTH(PIXEL_WIDTH)) bus ();

  scaler_h_linear #(
    .PIXEL_STEP (PIXEL_STEP),
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .COE_WIDTH  (COE_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int check_count = 0;
  int pass_count  = 0;
  int cycle_num   = 0;

  out_t exp_q[$];
  int   got_q[$];
  int   got_de_count;
  int   first_de_cycle;
  int   pix1_cycle;

  int                     model_px[$];
  longint                 model_k;
  int                     model_step_val;
  bit                     model_active;
  logic [PIXEL_WIDTH-1:0] model_last_do;
  int                     model_emit_q[$];

  function automatic out_t zero_out();
    out_t o;
    o.de  = 1'b0;
    o.hs  = 1'b0;
    o.vs  = 1'b0;
    o.dat = '0;
    return o;
  endfunction

  function automatic void reset_expect();
    exp_q.delete();
    repeat (3) exp_q.push_back(zero_out());
  endfunction

  function automatic void check_lit(input string name, input int got, input int want);
    check_count++;
    if (got == want) pass_count++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
  endfunction

  function automatic void check_seq(input string name, input int got[$], input int want[$]);
    bit ok;
    ok = (got.size() == want.size());
    if (ok) begin
      foreach (want[i]) if (got[i] != want[i]) ok = 1'b0;
    end
    check_count++;
    if (ok) pass_count++;
    else $display("[TB] FAIL %s: got %0d samples (first %0d), required %0d samples (first %0d)",
                  name, got.size(), (got.size() > 0) ? got[0] : -1,
                  want.size(), (want.size() > 0) ? want[0] : -1);
  endfunction

  // Behavioural model: output k sits at x = k*step and is produced by the
  // input pixel whose left neighbour's cell contains x.
  function automatic void model_update(input bit hs, input bit vs, input bit de, input int di);
    out_t   o;
    int     n;
    longint x;
    int     frac;
    int     coe;
    int     val;
    o     = zero_out();
    o.hs  = hs;
    o.vs  = vs;
    o.dat = model_last_do;
    if (!rst_n) begin
      model_px.delete();
      model_k        = 0;
      model_step_val = PIXEL_STEP;
      model_active   = 1'b0;
      model_last_do  = '0;
      o              = zero_out();
    end else begin
      if (hs) begin
        model_px.delete();
        model_k        = 0;
        model_step_val = (int'(bus.scale_step) < PIXEL_STEP) ? PIXEL_STEP : int'(bus.scale_step);
        model_active   = 1'b1;
      end
      if (de) begin
        model_px.push_back(di);
        n = model_px.size() - 1;
        if (n >= 1) begin
          x = model_k * model_step_val;
          if (x / PIXEL_STEP == n - 1) begin
            frac = int'(x % PIXEL_STEP);
            coe  = frac * (1 << COE_WIDTH) / PIXEL_STEP;
            val  = (model_px[n-1] * ((1 << COE_WIDTH) - coe) + model_px[n] * coe) >> COE_WIDTH;
            model_k++;
            if (model_active) begin
              o.de          = 1'b1;
              o.dat         = PIXEL_WIDTH'(val);
              model_last_do = PIXEL_WIDTH'(val);
              model_emit_q.push_back(val);
            end
          end
        end
      end
    end
    exp_q.push_back(o);
  endfunction

  task automatic checkOutput();
    out_t e;
    e = exp_q.pop_front();
    check_count++;
    if (bus.de_o === e.de && bus.hs_o === e.hs && bus.vs_o === e.vs && bus.do_o === e.dat)
      pass_count++;
    else
      $display("[TB] FAIL cycle_check @%0d: got de=%b hs=%b vs=%b do=%0d, required de=%b hs=%b vs=%b do=%0d",
               cycle_num, bus.de_o, bus.hs_o, bus.vs_o, bus.do_o, e.de, e.hs, e.vs, e.dat);
    if (bus.de_o === 1'b1) begin
      got_q.push_back(int'(bus.do_o));
      got_de_count++;
      if (first_de_cycle < 0) first_de_cycle = cycle_num;
    end
  endtask

  task automatic applyStimulus(input bit hs, input bit vs, input bit de, input logic [PIXEL_WIDTH-1:0] di);
    checkOutput();
    bus.hs_i = hs;
    bus.vs_i = vs;
    bus.de_i = de;
    bus.di_i = di;
    model_update(hs, vs, de, int'(di));
    cycle_num++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_line(input int step, input int px[$], input bit gapped, input bit frame_start);
    bus.scale_step = 16'(step);
    got_q.delete();
    model_emit_q.delete();
    got_de_count   = 0;
    first_de_cycle = -1;
    pix1_cycle     = -1;
    applyStimulus(1'b1, frame_start, 1'b0, '0);
    foreach (px[i]) begin
      if (gapped) applyStimulus(1'b0, 1'b0, 1'b0, '0);
      if (i == 1) pix1_cycle = cycle_num;
      applyStimulus(1'b0, 1'b0, 1'b1, PIXEL_WIDTH'(px[i]));
    end
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #20000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int px[$];
    int want[$];
    int wide[$];
    int width;
    bit coincident;

    bus.scale_step = 16'd128;
    bus.di_i = '0;
    bus.de_i = 1'b0;
    bus.hs_i = 1'b0;
    bus.vs_i = 1'b0;
    rst_n = 1'b0;
    model_px.delete();
    model_k = 0;
    model_step_val = PIXEL_STEP;
    model_active = 1'b0;
    model_last_do = '0;
    got_de_count = 0;
    first_de_cycle = -1;
    pix1_cycle = -1;
    reset_expect();
    @(negedge clk);

    $display("[TB] reset phase");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    check_lit("reset_do", int'(bus.do_o), 0);
    check_lit("reset_de", int'(bus.de_o), 0);
    check_lit("reset_hs", int'(bus.hs_o), 0);
    check_lit("reset_vs", int'(bus.vs_o), 0);
    rst_n = 1'b1;

    // Pixels ahead of the first line start must not produce output.
    got_de_count = 0;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, PIXEL_WIDTH'($urandom_range(0, 255)));
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    check_lit("pre_hs_silent", got_de_count, 0);

    $display("[TB] directed lines");
    px = '{10, 20, 30, 40};
    run_line(128, px, 1'b0, 1'b1);
    want = '{10, 20, 30};
    check_seq("unity_dut", got_q, want);
    check_seq("unity_model", model_emit_q, want);
    check_lit("unity_latency", first_de_cycle - pix1_cycle, 3);

    px = '{0, 10, 20, 30, 40};
    run_line(256, px, 1'b0, 1'b0);
    want = '{0, 20};
    check_seq("half_dut", got_q, want);
    check_seq("half_model", model_emit_q, want);

    px = '{0, 64, 128, 192};
    run_line(192, px, 1'b0, 1'b0);
    want = '{0, 96};
    check_seq("frac_dut", got_q, want);
    check_seq("frac_model", model_emit_q, want);

    px = '{10, 20, 30, 40};
    run_line(100, px, 1'b1, 1'b0);
    want = '{10, 20, 30};
    check_seq("clamp_dut", got_q, want);
    check_seq("clamp_model", model_emit_q, want);

    $display("[TB] randomized lines");
    for (int line = 0; line < 150; line++) begin
      bus.scale_step = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 127))
                                                   : 16'($urandom_range(128, 700));
      width      = $urandom_range(1, 40);
      coincident = ($urandom_range(0, 3) == 0);
      applyStimulus(1'b1, (line % 10) == 0, coincident, PIXEL_WIDTH'($urandom_range(0, 255)));
      for (int i = 0; i < width; i++) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, PIXEL_WIDTH'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 4) != 0) repeat ($urandom_range(0, 4)) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    end
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, '0);

    $display("[TB] wide lines at step 1.4");
    for (int pass = 0; pass < 2; pass++) begin
      for (int frame = 0; frame < 2; frame++) begin
        for (int line = 0; line < 2; line++) begin
          wide.delete();
          for (int i = 0; i < WIDE_W; i++) wide.push_back(int'($urandom_range(0, 255)));
          run_line(179, wide, pass == 1, line == 0);
          check_lit("wide_count_dut", got_de_count, 1922);
          check_lit("wide_count_model", model_emit_q.size(), 1922);
        end
      end
    end

    $display("[TB] reset mid-line");
    bus.scale_step = 16'd128;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int v = 10; v <= 60; v += 10) applyStimulus(1'b0, 1'b0, 1'b1, PIXEL_WIDTH'(v));
    check_lit("pre_reset_de", int'(bus.de_o), 1);
    rst_n = 1'b0;
    #1;
    check_lit("async_reset_do", int'(bus.do_o), 0);
    check_lit("async_reset_de", int'(bus.de_o), 0);
    check_lit("async_reset_hs", int'(bus.hs_o), 0);
    check_lit("async_reset_vs", int'(bus.vs_o), 0);
    reset_expect();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    px = '{10, 20, 30, 40};
    run_line(128, px, 1'b0, 1'b1);
    want = '{10, 20, 30};
    check_seq("post_reset_dut", got_q, want);
    check_seq("post_reset_model", model_emit_q, want);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
